vec3_serializer: RTL
====================

# vec3_serializer

Transmit side of the serial vec3 float stream consumed by the dot-product pipeline. Accepts pairs of parallel 3-component IEEE-754 single vectors over a valid/ready handshake, buffers them, and emits them one component per enabled cycle (x, y, z) on the lane-serial bus that feeds the multiply/accumulate chain. Framing markers let downstream logic tag which result belongs to which vector.

## Interface
- WIDTH, 32: component width in bits (IEEE-754 single).
- DEPTH, 2: input buffer entries, power of two ≥ 2; includes the entry being serialized.
- clock  in  1  rising-edge clock.
- aclr_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global pipeline enable; all state frozen when low.
- in_valid  in  1  producer has a vector pair.
- in_ready  out  1  buffer not full.
- in_v1  in  3*WIDTH  vector 1, x in [WIDTH-1:0], y next, z in top WIDTH bits.
- in_v2  in  3*WIDTH  vector 2, same packing.
- out_valid  out  1  out_v1/out_v2 hold a live component.
- out_first  out  1  current component is x.
- out_last  out  1  current component is z.
- out_lane  out  2  0=x, 1=y, 2=z; 3 never driven.
- out_v1  out  WIDTH  serialized component of vector 1.
- out_v2  out  WIDTH  serialized component of vector 2.
- vec_count  out  16  vectors fully emitted since reset, wraps at 2^16.

## Operation
- Accept: in_valid && in_ready && clk_en at a rising edge writes one entry into the buffer.
- in_ready = (occupancy < DEPTH), from registered occupancy only; no same-cycle bypass when full, even if the head pops on that edge.
- Serializer FSM, states IDLE, SX, SY, SZ, advancing only on enabled edges:
  - IDLE -> SX when buffer non-empty.
  - SX -> SY -> SZ unconditionally.
  - SZ -> SX if buffer holds another entry after this pop, else IDLE.
- Head entry stays in the buffer until its z is emitted; pop on the SX/SY/SZ edge that leaves SZ.
- Outputs registered: in SX/SY/SZ, out_valid=1, out_lane=0/1/2, out_first=(lane 0), out_last=(lane 2), out_v1/out_v2 = matching WIDTH slice of head entry.
- In IDLE: out_valid=0, out_first=0, out_last=0, out_lane=0, out_v1=out_v2=0 (downstream accumulators see zeros).
- vec_count increments on the edge leaving SZ, wraps 0xFFFF -> 0.
- No arithmetic on data; bits pass through unmodified (NaN/denormal untouched).

## Timing
- Reset (aclr_n low, async): buffer empty, FSM IDLE, in_ready=1, all other outputs 0. Mid-vector reset discards partial vector; out_valid drops immediately, not at next edge.
- Latency: entry accepted at edge N into empty idle block -> x visible after edge N+1, y after N+2, z after N+3.
- Throughput: one vector per 3 enabled cycles; back-to-back vectors with no idle gap (z of A followed directly by x of B).
- clk_en low: no accept, no FSM advance, no pop, outputs hold; in_ready still reflects occupancy.
- Simultaneous push and pop (not full): both take effect; occupancy unchanged.
- Full: in_ready=0 until the edge after a pop.

## Structure
- Shared package: default WIDTH, lane encodings LANE_X/LANE_Y/LANE_Z, FSM state enum, vec_count width.
- One sub-module: vec_fifo (synchronous circular buffer, 6*WIDTH wide, DEPTH entries, registered occupancy, full/empty flags, head read port). FSM, output registers and counter live in top level.

## Test plan
- Single vector: in_v1={z=0x40400000,y=0x40000000,x=0x3F800000}, in_v2 all 0x3F800000 at edge 0 -> edges 1..3 emit lanes 0,1,2 with out_v1 0x3F800000, 0x40000000, 0x40400000; out_first on lane 0, out_last on lane 2; out_valid=0 after edge 4; vec_count=1.
- Back-to-back: in_valid held high with 4 distinct vectors, DEPTH=2 -> 12 consecutive valid cycles, no gaps, order preserved, in_ready low whenever occupancy=2; vec_count=4.
- Full with pop same edge: buffer full, in_valid high during SZ -> no accept that edge; accept on following edge.
- clk_en toggling: clk_en low every other cycle during serialization -> outputs hold while low, same component sequence as with clk_en=1, latency counted in enabled edges only.
- Reset mid-vector: aclr_n low during SY -> out_valid, out_lane, vec_count, occupancy 0 asynchronously; after release, new vector serializes from x.
- Counter wrap: force 65536 vectors (or preload via bench force) -> vec_count reads 0 after last z.

Source files
------------

// File: rtl/vec3_serializer_pkg.sv
// Shared types and constants for the vec3 float serializer.
package vec3_serializer_pkg;

  localparam int unsigned DefWidth      = 32;
  localparam int unsigned VecCountWidth = 16;

  localparam logic [1:0] LANE_X = 2'd0;
  localparam logic [1:0] LANE_Y = 2'd1;
  localparam logic [1:0] LANE_Z = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StX    = 2'd1,
    StY    = 2'd2,
    StZ    = 2'd3
  } state_e;

  function automatic logic [1:0] state_lane(state_e st);
    logic [1:0] lane;
    unique case (st)
      StY:     lane = LANE_Y;
      StZ:     lane = LANE_Z;
      default: lane = LANE_X;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/vec3_serializer_if.sv
// Producer-side handshake plus lane-serial output bus of the vec3 serializer.
interface vec3_serializer_if #(
  parameter int unsigned WIDTH = vec3_serializer_pkg::DefWidth
);
  logic                                         in_valid;
  logic                                         in_ready;
  logic [3*WIDTH-1:0]                           in_v1;
  logic [3*WIDTH-1:0]                           in_v2;
  logic                                         out_valid;
  logic                                         out_first;
  logic                                         out_last;
  logic [1:0]                                   out_lane;
  logic [WIDTH-1:0]                             out_v1;
  logic [WIDTH-1:0]                             out_v2;
  logic [vec3_serializer_pkg::VecCountWidth-1:0] vec_count;

  modport master (
    output in_valid, in_v1, in_v2,
    input  in_ready, out_valid, out_first, out_last, out_lane, out_v1, out_v2, vec_count
  );

  modport slave (
    input  in_valid, in_v1, in_v2,
    output in_ready, out_valid, out_first, out_last, out_lane, out_v1, out_v2, vec_count
  );
endinterface

// File: rtl/vec3_serializer_vec_fifo.sv
// Circular buffer of vector pairs; exposes the head and the entry behind it.
module vec_fifo #(
  parameter int unsigned Width = 192,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         head_o,
  output logic [Width-1:0]         next_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [CntW-1:0]  count_q, count_d;

  // Power-of-two depth lets the pointers wrap by overflow.
  assign rd_next = rd_ptr_q + PtrW'(1);

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i ? rd_next : rd_ptr_q;
    count_d  = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_next];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/vec3_serializer.sv
// Buffers vec3 pairs and emits them one component per enabled cycle (x, y, z).
module vec3_serializer
  import vec3_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = 2
) (
  input logic               clock,
  input logic               aclr_n,
  input logic               clk_en,
  vec3_serializer_if.slave  bus
);
  localparam int unsigned EntryW = 6 * WIDTH;
  localparam int unsigned CntW   = $clog2(DEPTH) + 1;

  state_e              state_q, state_d;
  logic                push, pop, full, empty;
  logic [CntW-1:0]     count;
  logic [EntryW-1:0]   wdata, head, next_entry, head_sel;

  logic                out_valid_q, out_valid_d;
  logic                out_first_q, out_first_d;
  logic                out_last_q, out_last_d;
  logic [1:0]          out_lane_q, out_lane_d;
  logic [WIDTH-1:0]    out_v1_q, out_v1_d, out_v2_q, out_v2_d;
  logic [VecCountWidth-1:0] vec_count_q, vec_count_d;

  assign wdata        = {bus.in_v2, bus.in_v1};
  assign bus.in_ready = ~full;
  assign push         = clk_en & bus.in_valid & ~full;
  assign pop          = clk_en & (state_q == StZ);

  vec_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (aclr_n),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .head_o  (head),
    .next_o  (next_entry),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty) state_d = StX;
      StX:     state_d = StY;
      StY:     state_d = StZ;
      StZ:     state_d = (count > CntW'(1) || push) ? StX : StIdle;
      default: state_d = StIdle;
    endcase
    if (!clk_en) state_d = state_q;
  end

  // Entry that will be at the head after this edge; on a pop it is either
  // the one queued behind the head or the entry being pushed right now.
  always_comb begin
    head_sel = head;
    if (state_q == StZ) head_sel = (count > CntW'(1)) ? next_entry : wdata;
  end

  always_comb begin
    int unsigned off;
    out_valid_d = (state_d != StIdle);
    out_lane_d  = out_valid_d ? state_lane(state_d) : LANE_X;
    out_first_d = out_valid_d && (out_lane_d == LANE_X);
    out_last_d  = out_valid_d && (out_lane_d == LANE_Z);
    off         = 32'(out_lane_d) * WIDTH;
    out_v1_d    = out_valid_d ? head_sel[off +: WIDTH] : '0;
    out_v2_d    = out_valid_d ? head_sel[3*WIDTH + off +: WIDTH] : '0;
    vec_count_d = pop ? vec_count_q + VecCountWidth'(1) : vec_count_q;
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_lane_q  <= LANE_X;
      out_v1_q    <= '0;
      out_v2_q    <= '0;
      vec_count_q <= '0;
    end else if (clk_en) begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_lane_q  <= out_lane_d;
      out_v1_q    <= out_v1_d;
      out_v2_q    <= out_v2_d;
      vec_count_q <= vec_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_lane  = out_lane_q;
  assign bus.out_v1    = out_v1_q;
  assign bus.out_v2    = out_v2_q;
  assign bus.vec_count = vec_count_q;

endmodule
